// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared converter state, widths and limits for freq_meas_ctrl
package freq_meas_pkg;
  localparam int CNT_W = 12;
  localparam int BCD_DIGITS = 4;
  localparam int SHIFT_W = 28;
  localparam int CNT_MAX = 4095;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;
endpackage

// File: rtl/freq_meas_ctrl_bcd_dd_step.sv
// bcd_dd_step: one double-dabble iteration (add 3 to BCD nibbles >= 5, shift left); in i_shift[27:0], out o_shift[27:0]
module bcd_dd_step import freq_meas_pkg::*; (
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [SHIFT_W-1:0] o_shift
);
  logic [SHIFT_W-1:0] w_adj;
  always_comb begin
    w_adj = i_shift;
    for (int k = 0; k < BCD_DIGITS; k++)
      w_adj[CNT_W+4*k +: 4] = (i_shift[CNT_W+4*k +: 4] >= 4'd5) ? i_shift[CNT_W+4*k +: 4] + 4'd3 : i_shift[CNT_W+4*k +: 4];
    o_shift = {w_adj[SHIFT_W-2:0], 1'b0};
  end
endmodule

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: gated edge counter + BCD converter; in clk rst en sig_in, out thousands hundreds tens ones valid overflow busy, plus blank[3:0] when FREQ_LZ_BLANK_EN is defined
module freq_meas_ctrl import freq_meas_pkg::*; #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sig_in,
  output logic [3:0] thousands,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic       overflow,
  output logic       busy
`ifdef FREQ_LZ_BLANK_EN
  ,
  output logic [3:0] blank
`endif
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  if (GATE_CYCLES < 16) begin : g_gate_chk
    $error("GATE_CYCLES must be at least 16");
  end
  if (CNT_W != 12) begin : g_w_chk
    $error("CNT_W is fixed at 12");
  end
  logic r_s1, r_s2, r_s3;
  logic [GW-1:0] r_gate;
  logic [CNT_W-1:0] r_cnt;
  logic r_sat;
  conv_state_e r_state, w_state;
  logic [SHIFT_W-1:0] r_shift, w_step;
  logic [3:0] r_iter;
  logic r_lsat;
  logic [15:0] r_bcd;
  logic r_ovf;
  logic w_rise, w_end, w_full, w_sat, w_last;
  logic [CNT_W-1:0] w_cnt;
  assign w_rise = r_s2 & ~r_s3;
  assign w_end = en && (r_gate == GATE_LAST);
  assign w_full = (r_cnt == CNT_W'(CNT_MAX));
  // count/sat including this cycle's edge, so the window-end edge lands in the result
  assign w_cnt = (w_rise && !w_full) ? r_cnt + 1'b1 : r_cnt;
  assign w_sat = r_sat | (w_rise & w_full);
  assign w_last = (r_state == CONV) && (r_iter == 4'd11);
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s3, r_s2, r_s1} <= '0;
      r_gate <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, sig_in};
      r_gate <= (!en || w_end) ? '0 : r_gate + 1'b1;
      r_cnt <= (!en || w_end) ? '0 : w_cnt;
      r_sat <= en && !w_end && w_sat;
    end
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state;
  always_comb begin
    w_state = (r_state == IDLE) ? (w_end ? CONV : IDLE) : (r_state == CONV) ? (w_last ? DONE : CONV) : IDLE;
    valid = (r_state == DONE);
    busy = (r_state != IDLE);
  end
  bcd_dd_step u_step (.i_shift(r_shift), .o_shift(w_step));
`ifdef FREQ_LZ_BLANK_EN
  logic [3:0] r_blank;
  assign blank = r_blank;
`endif
  // digits are published on the last iteration so they change together with valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_iter <= '0;
      r_lsat <= 1'b0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
`ifdef FREQ_LZ_BLANK_EN
      r_blank <= 4'b1110;
`endif
    end else begin
      if (r_state == IDLE && w_end) begin
        r_shift <= {{(SHIFT_W-CNT_W){1'b0}}, w_cnt};
        r_iter <= '0;
        r_lsat <= w_sat;
      end else if (r_state == CONV) begin
        r_shift <= w_step;
        r_iter <= r_iter + 1'b1;
      end
      if (w_last) begin
        r_bcd <= w_step[27:12];
        r_ovf <= r_lsat;
`ifdef FREQ_LZ_BLANK_EN
        r_blank[3] <= (w_step[27:24] == 4'd0);
        r_blank[2] <= (w_step[27:20] == 8'd0);
        r_blank[1] <= (w_step[27:16] == 12'd0);
        r_blank[0] <= 1'b0;
`endif
      end
    end
  end
  assign {thousands, hundreds, tens, ones} = r_bcd;
  assign overflow = r_ovf;
endmodule
